sarray_tinst_seq: RTL

- Parametrised tile-instruction sequencer for the systolic array. Successor to the single-mode tile front-end.
- Accepts one tile instruction at a time: TMMA, PRELOADA, PRELOADC, or the new STOREC mode.
- Generates row-strided read requests with a bounded number in flight, and routes returned beats to the A ping-pong buffer or to the array feed.
- Drains array results to memory via the write channel (STOREC). Sits between the tile issue stage and the memory port / array shift registers.

---
 rtl/sarray_tinst_seq.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/sarray_tinst_seq.sv
// Tile-instruction sequencer for the systolic array. It issues row-strided loads
// into the A ping-pong buffer or the array feed, and drains array results (STOREC).
module sarray_tinst_seq #(
  parameter int ADDR_WIDTH  = 64,
  parameter int LOAD_WIDTH  = 256,
  parameter int STORE_WIDTH = 256,
  parameter int ROWS        = 64,
  parameter int ROW_STRIDE  = 256,
  parameter int MAX_OUT     = 8,
  parameter int PREC_WIDTH  = 1,
  parameter int CNT_WIDTH   = $clog2(ROWS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   issue_tinst_valid_i,
  output logic                   issue_tinst_ready_o,
  input  logic [1:0]             issue_tinst_type_i,
  input  logic [ADDR_WIDTH-1:0]  issue_tinst_addr0_i,
  input  logic [ADDR_WIDTH-1:0]  issue_tinst_addr1_i,
  input  logic [PREC_WIDTH-1:0]  issue_tinst_precision_i,
  input  logic                   issue_tinst_acc_i,
  output logic                   sarray_ar_valid_o,
  input  logic                   sarray_ar_ready_i,
  output logic [ADDR_WIDTH-1:0]  sarray_ar_addr_o,
  input  logic                   sarray_r_valid_i,
  output logic                   sarray_r_ready_o,
  input  logic [LOAD_WIDTH-1:0]  sarray_r_data_i,
  output logic                   sarray_aw_valid_o,
  input  logic                   sarray_aw_ready_i,
  output logic [ADDR_WIDTH-1:0]  sarray_aw_addr_o,
  output logic [STORE_WIDTH-1:0] sarray_aw_data_o,
  output logic                   wr_a_buf_valid_o,
  output logic                   wr_a_buf_id_o,
  output logic [CNT_WIDTH-1:0]   wr_a_buf_addr_o,
  output logic [LOAD_WIDTH-1:0]  wr_a_buf_data_o,
  output logic                   rd_a_buf_id_o,
  output logic                   feed_valid_o,
  input  logic                   feed_ready_i,
  output logic [1:0]             feed_type_o,
  output logic [CNT_WIDTH-1:0]   feed_cnt_o,
  output logic [LOAD_WIDTH-1:0]  feed_data_o,
  output logic [PREC_WIDTH-1:0]  feed_precision_o,
  output logic                   feed_acc_o,
  input  logic                   bot_valid_i,
  output logic                   bot_ready_o,
  input  logic [STORE_WIDTH-1:0] bot_data_i,
  output logic                   busy_o,
  output logic                   done_o
);

  localparam int OUT_W = $clog2(MAX_OUT + 1);
  localparam logic [CNT_WIDTH:0]    AR_LIMIT  = (CNT_WIDTH + 1)'(ROWS);
  localparam logic [CNT_WIDTH-1:0]  LAST_ROW  = CNT_WIDTH'(ROWS - 1);
  localparam logic [OUT_W-1:0]      OUT_LIMIT = OUT_W'(MAX_OUT);
  localparam logic [ADDR_WIDTH-1:0] STRIDE    = ADDR_WIDTH'(ROW_STRIDE);

  typedef enum logic [1:0] {IDLE, LOAD, STORE, DONE} state_e;
  typedef enum logic [1:0] {
    T_TMMA     = 2'd0,
    T_PRELOADA = 2'd1,
    T_PRELOADC = 2'd2,
    T_STOREC   = 2'd3
  } tinst_e;

  state_e                  state_q, state_d;
  tinst_e                  type_q, type_d;
  logic [ADDR_WIDTH-1:0]   addr0_q, addr0_d;
  logic [ADDR_WIDTH-1:0]   addr1_q, addr1_d;
  logic [PREC_WIDTH-1:0]   prec_q, prec_d;
  logic                    acc_q, acc_d;
  logic [CNT_WIDTH:0]      ar_cnt_q, ar_cnt_d;
  logic [CNT_WIDTH-1:0]    r_cnt_q, r_cnt_d;
  logic [CNT_WIDTH-1:0]    st_cnt_q, st_cnt_d;
  logic [OUT_W-1:0]        out_cnt_q, out_cnt_d;
  logic                    wr_id_q, wr_id_d;
  logic                    rd_id_q, rd_id_d;

  logic                    is_load, is_store, is_prea, out_nz;
  logic                    ar_valid, r_ready, ar_hsk, r_hsk, aw_valid, aw_hsk;
  logic [ADDR_WIDTH-1:0]   base_addr;

  assign is_load   = (state_q == LOAD);
  assign is_store  = (state_q == STORE);
  assign is_prea   = (type_q == T_PRELOADA);
  assign out_nz    = (out_cnt_q != '0);
  assign base_addr = (type_q == T_TMMA) ? addr1_q : addr0_q;

  assign ar_valid  = is_load & (ar_cnt_q < AR_LIMIT) & (out_cnt_q < OUT_LIMIT);
  assign ar_hsk    = ar_valid & sarray_ar_ready_i;
  // PRELOADA beats land in the A buffer unconditionally; feed beats obey feed back-pressure.
  assign r_ready   = is_load & out_nz & (is_prea | feed_ready_i);
  assign r_hsk     = sarray_r_valid_i & r_ready;
  assign aw_valid  = is_store & bot_valid_i;
  assign aw_hsk    = aw_valid & sarray_aw_ready_i;

  assign issue_tinst_ready_o = (state_q == IDLE);
  assign busy_o              = (state_q != IDLE);
  assign done_o              = (state_q == DONE);

  assign sarray_ar_valid_o = ar_valid;
  assign sarray_ar_addr_o  = base_addr + ADDR_WIDTH'(ar_cnt_q) * STRIDE;
  assign sarray_r_ready_o  = r_ready;

  assign sarray_aw_valid_o = aw_valid;
  assign sarray_aw_addr_o  = addr0_q + ADDR_WIDTH'(st_cnt_q) * STRIDE;
  assign sarray_aw_data_o  = aw_valid ? bot_data_i : '0;
  assign bot_ready_o       = is_store & sarray_aw_ready_i;

  assign wr_a_buf_valid_o  = r_hsk & is_prea;
  assign wr_a_buf_id_o     = wr_id_q;
  assign wr_a_buf_addr_o   = r_cnt_q;
  assign wr_a_buf_data_o   = wr_a_buf_valid_o ? sarray_r_data_i : '0;
  assign rd_a_buf_id_o     = rd_id_q;

  assign feed_valid_o      = is_load & ~is_prea & sarray_r_valid_i & out_nz;
  assign feed_type_o       = type_q;
  assign feed_cnt_o        = r_cnt_q;
  assign feed_data_o       = feed_valid_o ? sarray_r_data_i : '0;
  assign feed_precision_o  = prec_q;
  assign feed_acc_o        = acc_q;

  always_comb begin
    state_d   = state_q;
    type_d    = type_q;
    addr0_d   = addr0_q;
    addr1_d   = addr1_q;
    prec_d    = prec_q;
    acc_d     = acc_q;
    ar_cnt_d  = ar_cnt_q;
    r_cnt_d   = r_cnt_q;
    st_cnt_d  = st_cnt_q;
    out_cnt_d = out_cnt_q;
    wr_id_d   = wr_id_q;
    rd_id_d   = rd_id_q;
    case (state_q)
      IDLE: begin
        if (issue_tinst_valid_i) begin
          type_d    = tinst_e'(issue_tinst_type_i);
          addr0_d   = issue_tinst_addr0_i;
          addr1_d   = issue_tinst_addr1_i;
          prec_d    = issue_tinst_precision_i;
          acc_d     = issue_tinst_acc_i;
          ar_cnt_d  = '0;
          r_cnt_d   = '0;
          st_cnt_d  = '0;
          out_cnt_d = '0;
          state_d   = (tinst_e'(issue_tinst_type_i) == T_STOREC) ? STORE : LOAD;
        end
      end
      LOAD: begin
        if (ar_hsk) ar_cnt_d = ar_cnt_q + (CNT_WIDTH + 1)'(1);
        case ({ar_hsk, r_hsk})
          2'b10:   out_cnt_d = out_cnt_q + OUT_W'(1);
          2'b01:   out_cnt_d = out_cnt_q - OUT_W'(1);
          default: out_cnt_d = out_cnt_q;
        endcase
        if (r_hsk) begin
          r_cnt_d = r_cnt_q + CNT_WIDTH'(1);
          if (r_cnt_q == LAST_ROW) begin
            state_d = DONE;
            // A freshly loaded bank becomes the TMMA read bank only once it is complete.
            if (is_prea) begin
              rd_id_d = wr_id_q;
              wr_id_d = ~wr_id_q;
            end
          end
        end
      end
      STORE: begin
        if (aw_hsk) begin
          st_cnt_d = st_cnt_q + CNT_WIDTH'(1);
          if (st_cnt_q == LAST_ROW) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      type_q    <= T_TMMA;
      addr0_q   <= '0;
      addr1_q   <= '0;
      prec_q    <= '0;
      acc_q     <= 1'b0;
      ar_cnt_q  <= '0;
      r_cnt_q   <= '0;
      st_cnt_q  <= '0;
      out_cnt_q <= '0;
      wr_id_q   <= 1'b0;
      rd_id_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      type_q    <= type_d;
      addr0_q   <= addr0_d;
      addr1_q   <= addr1_d;
      prec_q    <= prec_d;
      acc_q     <= acc_d;
      ar_cnt_q  <= ar_cnt_d;
      r_cnt_q   <= r_cnt_d;
      st_cnt_q  <= st_cnt_d;
      out_cnt_q <= out_cnt_d;
      wr_id_q   <= wr_id_d;
      rd_id_q   <= rd_id_d;
    end
  end

endmodule
